start_done_sequencer: RTL and testbench



---
 rtl/start_done_sequencer.sv | 134 +++++++++++++
 tb/tb_start_done_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/start_done_sequencer.sv
// Start/done handshake sequencer: issues PULSE_W-cycle start pulses, waits for each done rising edge,
// and ends a run after run_len starts (0 = free-run). Define SEQ_TIMEOUT_EN to compile in the WAIT watchdog.
module start_done_sequencer #(
  parameter int COUNT_W     = 8,
  parameter int PULSE_W     = 2,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               done,
  input  logic [COUNT_W-1:0] run_len,
  output logic               start,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               run_done,
  output logic               timeout
);

  localparam int             PC_W    = $clog2(PULSE_W + 1);
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(PULSE_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state;
  logic               done_q;
  logic [COUNT_W-1:0] len_r;
  logic [PC_W-1:0]    pcnt;
  logic               done_rise;
  logic               go_on;
  logic               wd_hit;

  if (PULSE_W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("start_done_sequencer: PULSE_W and TIMEOUT_CYC must be >= 1");
  end

  assign done_rise = done & ~done_q;
  assign go_on     = enable && ((len_r == '0) || (count != len_r));

`ifdef SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd;
  logic            timeout_r;

  assign wd_hit  = (wd == WD_LAST);
  assign timeout = timeout_r;

  // Watchdog runs only while waiting; it is held at zero in every other state so WAIT always starts from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd        <= '0;
      timeout_r <= 1'b0;
    end else begin
      if (state == IDLE && enable)
        timeout_r <= 1'b0;
      else if (state == WAIT && !done_rise && wd_hit)
        timeout_r <= 1'b1;
      if (state == WAIT)
        wd <= wd + 1'b1;
      else
        wd <= '0;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      len_r    <= '0;
      pcnt     <= '0;
      count    <= '0;
      start    <= 1'b0;
      busy     <= 1'b0;
      run_done <= 1'b0;
    end else begin
      done_q   <= done;
      run_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable) begin
            len_r <= run_len;
            count <= COUNT_W'(1);
            pcnt  <= PC_LOAD;
            start <= 1'b1;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          // done edges seen here are deliberately dropped; completion must rise again in WAIT
          if (pcnt == PC_W'(1)) begin
            start <= 1'b0;
            state <= WAIT;
          end else begin
            pcnt <= pcnt - 1'b1;
          end
        end
        WAIT: begin
          if (done_rise) begin
            if (go_on) begin
              count <= count + 1'b1;
              pcnt  <= PC_LOAD;
              start <= 1'b1;
              state <= START;
            end else begin
              busy     <= 1'b0;
              run_done <= 1'b1;
              state    <= IDLE;
            end
          end else if (wd_hit) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          start <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_done_sequencer.sv
// Bench for start_done_sequencer (COUNT_W=4, PULSE_W=2, TIMEOUT_CYC=8); watchdog cases follow SEQ_TIMEOUT_EN.
module tb_start_done_sequencer;

  localparam int CW = 4;
  localparam int PW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          done = 1'b0;
  logic [CW-1:0] run_len = '0;
  logic          start;
  logic [CW-1:0] count;
  logic          busy;
  logic          run_done;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  start_done_sequencer #(.COUNT_W(CW), .PULSE_W(PW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .done(done), .run_len(run_len),
    .start(start), .count(count), .busy(busy), .run_done(run_done), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          en;
    logic          dn;
    logic [CW-1:0] len;
    logic          s;
    logic [CW-1:0] c;
    logic          b;
    logic          rd;
  } vec_t;

  vec_t tbl [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    done   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // One start/done exchange: wait for start, measure its width, idle `delay` WAIT cycles, then raise done once.
  task automatic handshake(input int exp_cnt, input int delay, input bit drop_en, output int waited);
    int w;
    waited = 0;
    while (start !== 1'b1 && waited < 50) begin
      step();
      waited++;
    end
    chk("start_seen", start, 1);
    chk($sformatf("count_at_start_%0d", exp_cnt), count, exp_cnt & ((1 << CW) - 1));
    w = 0;
    while (start === 1'b1 && w < 20) begin
      w++;
      if (drop_en) enable = 1'b0;
      step();
    end
    chk("start_width", w, PW);
    repeat (delay) step();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int waited;
    int len, drop, n;

    tbl[0]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 4'd2, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 4'd2, 1'b0, 4'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 4'd2, 1'b0, 4'd2, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 4'd2, 1'b0, 4'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 4'd1, 1'b1, 4'd1, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 4'd1, 1'b0, 4'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 4'd1, 1'b0, 4'd1, 1'b0, 1'b0};

    // Reset state
    step();
    chk("rst_start", start, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_done", run_done, 0);
    chk("rst_timeout", timeout, 0);

    // Asynchronous reset in the middle of a start pulse
    rst_n   = 1'b1;
    run_len = 4'd3;
    enable  = 1'b1;
    step();
    chk("pre_rst_start", start, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_start", start, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_busy", busy, 0);
    enable = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_idle_busy", busy, 0);
    chk("post_rst_idle_start", start, 0);

    // Cycle-by-cycle vector table
    do_reset();
    for (int i = 0; i < 15; i++) begin
      enable  = tbl[i].en;
      done    = tbl[i].dn;
      run_len = tbl[i].len;
      step();
      chk($sformatf("tbl%0d_start", i), start, tbl[i].s);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].c);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].b);
      chk($sformatf("tbl%0d_run_done", i), run_done, tbl[i].rd);
    end
    done = 1'b0;

    // run_len=3 with done arriving 3 cycles after each start
    do_reset();
    run_len = 4'd3;
    enable  = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      handshake(k, 1, 1'b0, waited);
      if (k < 3) chk("len3_next_start", start, 1);
    end
    chk("len3_run_done", run_done, 1);
    chk("len3_busy", busy, 0);
    chk("len3_count", count, 3);
    enable = 1'b0;
    step();
    chk("len3_run_done_one_cycle", run_done, 0);

    // Free-run wrap over 17 handshakes
    do_reset();
    run_len = 4'd0;
    enable  = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      handshake(k, k % 3, k == 17, waited);
      if (k < 17) begin
        chk($sformatf("free_start_%0d", k), start, 1);
        chk($sformatf("free_no_run_done_%0d", k), run_done, 0);
      end
    end
    chk("free_end_run_done", run_done, 1);
    chk("free_end_count", count, 1);

    // Enable dropped during the second start of a run_len=5 run
    do_reset();
    run_len = 4'd5;
    enable  = 1'b1;
    handshake(1, 0, 1'b0, waited);
    handshake(2, 2, 1'b1, waited);
    chk("drop_run_done", run_done, 1);
    chk("drop_count", count, 2);
    chk("drop_busy", busy, 0);
    repeat (4) step();
    chk("drop_no_third_start", start, 0);
    chk("drop_count_hold", count, 2);

    // done held high through START needs a fresh rising edge in WAIT
    do_reset();
    run_len = 4'd2;
    enable  = 1'b1;
    step();
    chk("held_first_start", start, 1);
    done = 1'b1;
    step();
    step();
    chk("held_in_wait", start, 0);
    repeat (4) step();
    chk("held_no_progress_start", start, 0);
    chk("held_no_progress_count", count, 1);
    chk("held_still_busy", busy, 1);
    done = 1'b0;
    step();
    done = 1'b1;
    step();
    chk("held_rerise_start", start, 1);
    chk("held_rerise_count", count, 2);
    done = 1'b0;
    handshake(2, 0, 1'b0, waited);
    chk("held_zero_gap", waited, 0);
    chk("held_run_done", run_done, 1);
    enable = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // Watchdog expiry, then next run clears timeout, then done_rise on the expiry cycle wins
    do_reset();
    run_len = 4'd3;
    enable  = 1'b1;
    step();
    step();
    step();
    chk("wd_enter_wait", start, 0);
    repeat (TO - 1) step();
    chk("wd_busy_before_expiry", busy, 1);
    step();
    chk("wd_busy_after", busy, 0);
    chk("wd_timeout", timeout, 1);
    chk("wd_no_run_done", run_done, 0);
    chk("wd_count_hold", count, 1);
    step();
    chk("wd_restart_start", start, 1);
    chk("wd_restart_clears", timeout, 0);
    step();
    step();
    repeat (TO - 1) step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("wd_race_start", start, 1);
    chk("wd_race_count", count, 2);
    chk("wd_race_timeout", timeout, 0);
`else
    // Without the watchdog WAIT never gives up
    do_reset();
    run_len = 4'd3;
    enable  = 1'b1;
    repeat (3 + 4 * TO) step();
    chk("nowd_still_busy", busy, 1);
    chk("nowd_timeout_low", timeout, 0);
    chk("nowd_count", count, 1);
`endif

    // Randomized runs against a run-level reference: expected number of starts from run_len and drop point
    do_reset();
    for (int r = 0; r < 25; r++) begin
      len  = $urandom_range(0, 5);
      drop = (len == 0) ? $urandom_range(1, 6) : $urandom_range(0, 6);
      if (len == 0)
        n = drop;
      else if (drop == 0 || drop >= len)
        n = len;
      else
        n = drop;
      run_len = CW'(len);
      enable  = 1'b1;
      for (int k = 1; k <= n; k++) begin
        handshake(k, $urandom_range(0, 3), (drop != 0) && (k == drop), waited);
        chk($sformatf("rnd%0d_gap_%0d", r, k), waited, (k == 1) ? 1 : 0);
        if (k < n) begin
          chk($sformatf("rnd%0d_cont_%0d", r, k), start, 1);
          chk($sformatf("rnd%0d_no_rd_%0d", r, k), run_done, 0);
        end
      end
      chk($sformatf("rnd%0d_run_done", r), run_done, 1);
      chk($sformatf("rnd%0d_busy", r), busy, 0);
      chk($sformatf("rnd%0d_count", r), count, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
